// File: rtl/data_table_search_pkg.sv
// Shared types and constants for the hash-table search pipeline: request,
// data RAM entry and search result layouts.
package data_table_search_pkg;

   localparam int unsigned HT_PTR_WIDTH    = 8;
   localparam int unsigned KEY_WIDTH       = 16;
   localparam int unsigned VALUE_WIDTH     = 16;
   localparam int unsigned BUCKET_WIDTH    = 8;
   localparam int unsigned MAX_CHAIN_LEN   = 8;

   typedef enum logic [1:0] {
      OP_SEARCH = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2
   } ht_opcode_e;

   typedef struct packed {
      ht_opcode_e             opcode;
      logic [KEY_WIDTH-1:0]   key;
   } ht_cmd_t;

   typedef struct packed {
      ht_cmd_t                  cmd;
      logic [BUCKET_WIDTH-1:0]  bucket;
      logic [HT_PTR_WIDTH-1:0]  head_ptr;
      logic                     head_ptr_val;
   } ht_pdata_t;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]     key;
      logic [VALUE_WIDTH-1:0]   value;
      logic [HT_PTR_WIDTH-1:0]  next_ptr;
      logic                     next_ptr_val;
   } data_ram_data_t;

   typedef struct packed {
      ht_pdata_t                pdata;
      logic                     found;
      logic [HT_PTR_WIDTH-1:0]  found_ptr;
      logic [HT_PTR_WIDTH-1:0]  prev_ptr;
      logic                     prev_ptr_val;
      logic [VALUE_WIDTH-1:0]   value;
      logic                     chain_err;
   } ht_search_result_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_OUT   = 2'd2
   } dts_state_e;

endpackage

// File: rtl/data_table_search.sv
// Walks one bucket's linked list in the data RAM per request and emits a
// registered hit/miss result with matched, predecessor and tail pointers.
module data_table_search
   import data_table_search_pkg::*;
#(
   parameter int unsigned MAX_CHAIN = MAX_CHAIN_LEN,
   parameter int unsigned PTR_WIDTH = HT_PTR_WIDTH
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [$bits(ht_pdata_t)-1:0]          pdata_in_i,
   input  logic                                  pdata_in_valid_i,
   output logic                                  pdata_in_ready_o,
   output logic [PTR_WIDTH-1:0]                  rd_addr_o,
   output logic                                  rd_en_o,
   input  logic [$bits(data_ram_data_t)-1:0]     rd_data_i,
   output logic [$bits(ht_search_result_t)-1:0]  result_o,
   output logic                                  result_valid_o,
   input  logic                                  result_ready_i
);

   localparam int unsigned HOP_W = $clog2(MAX_CHAIN + 1);

   dts_state_e               state_q, state_d;
   ht_pdata_t                pdata_in;
   ht_pdata_t                pdata_q, pdata_d;
   data_ram_data_t           rd_data;
   ht_search_result_t        result_q, result_d;
   logic                     result_valid_q, result_valid_d;
   logic [HT_PTR_WIDTH-1:0]  cur_ptr_q, cur_ptr_d;
   logic [HT_PTR_WIDTH-1:0]  prev_ptr_q, prev_ptr_d;
   logic                     prev_ptr_val_q, prev_ptr_val_d;
   logic [HOP_W-1:0]         hop_q, hop_d;
   logic [HT_PTR_WIDTH-1:0]  rd_addr_c;
   logic                     rd_en_c;
   logic                     accept;
   logic                     key_hit;

   assign pdata_in = ht_pdata_t'(pdata_in_i);
   assign rd_data  = data_ram_data_t'(rd_data_i);

   // Reset is asynchronous, so the handshake outputs are also masked by it directly.
   assign pdata_in_ready_o = (state_q == ST_IDLE) && !rst_i;
   assign accept           = pdata_in_valid_i && pdata_in_ready_o;
   assign key_hit          = (rd_data.key == pdata_q.cmd.key);

   assign rd_addr_o      = PTR_WIDTH'(rd_addr_c);
   assign rd_en_o        = rd_en_c && !rst_i;
   assign result_o       = result_q;
   assign result_valid_o = result_valid_q;

   always_comb begin
      state_d        = state_q;
      pdata_d        = pdata_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      cur_ptr_d      = cur_ptr_q;
      prev_ptr_d     = prev_ptr_q;
      prev_ptr_val_d = prev_ptr_val_q;
      hop_d          = hop_q;
      rd_addr_c      = pdata_in.head_ptr;
      rd_en_c        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            rd_addr_c = pdata_in.head_ptr;
            rd_en_c   = accept && pdata_in.head_ptr_val;
            if (accept) begin
               pdata_d        = pdata_in;
               prev_ptr_d     = '0;
               prev_ptr_val_d = 1'b0;
               if (pdata_in.head_ptr_val) begin
                  state_d   = ST_CHECK;
                  cur_ptr_d = pdata_in.head_ptr;
                  hop_d     = HOP_W'(1);
               end else begin
                  state_d        = ST_OUT;
                  result_d       = '0;
                  result_d.pdata = pdata_in;
                  result_valid_d = 1'b1;
               end
            end
         end

         ST_CHECK: begin
            rd_addr_c = rd_data.next_ptr;
            if (key_hit) begin
               state_d               = ST_OUT;
               result_d              = '0;
               result_d.pdata        = pdata_q;
               result_d.found        = 1'b1;
               result_d.found_ptr    = cur_ptr_q;
               result_d.prev_ptr     = prev_ptr_q;
               result_d.prev_ptr_val = prev_ptr_val_q;
               result_d.value        = rd_data.value;
               result_valid_d        = 1'b1;
            end else if (!rd_data.next_ptr_val) begin
               // Miss at the tail: report the tail so an insert can append to it.
               state_d               = ST_OUT;
               result_d              = '0;
               result_d.pdata        = pdata_q;
               result_d.prev_ptr     = cur_ptr_q;
               result_d.prev_ptr_val = 1'b1;
               result_valid_d        = 1'b1;
            end else if (hop_q == HOP_W'(MAX_CHAIN)) begin
               state_d               = ST_OUT;
               result_d              = '0;
               result_d.pdata        = pdata_q;
               result_d.prev_ptr     = prev_ptr_q;
               result_d.prev_ptr_val = prev_ptr_val_q;
               result_d.chain_err    = 1'b1;
               result_valid_d        = 1'b1;
            end else begin
               rd_en_c        = 1'b1;
               prev_ptr_d     = cur_ptr_q;
               prev_ptr_val_d = 1'b1;
               cur_ptr_d      = rd_data.next_ptr;
               hop_d          = hop_q + HOP_W'(1);
            end
         end

         ST_OUT: begin
            if (result_ready_i) begin
               state_d        = ST_IDLE;
               result_valid_d = 1'b0;
            end
         end

         default: begin
            state_d        = ST_IDLE;
            result_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         pdata_q        <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         cur_ptr_q      <= '0;
         prev_ptr_q     <= '0;
         prev_ptr_val_q <= 1'b0;
         hop_q          <= '0;
      end else begin
         state_q        <= state_d;
         pdata_q        <= pdata_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         cur_ptr_q      <= cur_ptr_d;
         prev_ptr_q     <= prev_ptr_d;
         prev_ptr_val_q <= prev_ptr_val_d;
         hop_q          <= hop_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i && result_valid_q && result_ready_i) begin
         $display("data_table_search: op=%0d key=%0h found=%0b found_ptr=%0h chain_err=%0b",
                  result_q.pdata.cmd.opcode, result_q.pdata.cmd.key, result_q.found,
                  result_q.found_ptr, result_q.chain_err);
      end
   end
`endif

endmodule

// File: tb/tb_data_table_search.sv
// Directed bench for data_table_search: empty bucket, head/mid hits, tail miss,
// loop with backpressure, and reset during a walk.
module tb_data_table_search;
   import data_table_search_pkg::*;

   logic                                  clk;
   logic                                  rst;
   logic [$bits(ht_pdata_t)-1:0]          pdata_in;
   logic                                  pdata_in_valid;
   logic                                  pdata_in_ready;
   logic [7:0]                            rd_addr;
   logic                                  rd_en;
   logic [$bits(data_ram_data_t)-1:0]     rd_data;
   logic [$bits(ht_search_result_t)-1:0]  result;
   logic                                  result_valid;
   logic                                  result_ready;

   ht_search_result_t res;
   ht_pdata_t         req_last;
   data_ram_data_t    mem [256];
   logic [7:0]        rd_log [16];
   int unsigned       nreads;
   int unsigned       total;
   int unsigned       bad;

   assign res = result;

   data_table_search #(.MAX_CHAIN(4), .PTR_WIDTH(8)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .pdata_in_i       (pdata_in),
      .pdata_in_valid_i (pdata_in_valid),
      .pdata_in_ready_o (pdata_in_ready),
      .rd_addr_o        (rd_addr),
      .rd_en_o          (rd_en),
      .rd_data_i        (rd_data),
      .result_o         (result),
      .result_valid_o   (result_valid),
      .result_ready_i   (result_ready)
   );

   always #5 clk = ~clk;

   // One-cycle-latency data RAM read port
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         if (nreads < 16) rd_log[nreads] = rd_addr;
         nreads = nreads + 1;
      end
   end

   task automatic set_ram(input int unsigned a, input logic [15:0] k, input logic [15:0] v,
                          input logic [7:0] nx, input logic nv);
      mem[a].key          = k;
      mem[a].value        = v;
      mem[a].next_ptr     = nx;
      mem[a].next_ptr_val = nv;
   endtask

   // Called at posedge+1; returns cycles from the accept edge to result_valid.
   task automatic send_req(input logic [15:0] key, input logic [7:0] head, input logic hv,
                           output int unsigned lat);
      ht_pdata_t r;
      r = '0;
      r.cmd.opcode   = OP_SEARCH;
      r.cmd.key      = key;
      r.bucket       = 8'h3C;
      r.head_ptr     = head;
      r.head_ptr_val = hv;
      req_last       = r;
      nreads         = 0;
      pdata_in       = r;
      pdata_in_valid = 1'b1;
      total++;
      if (pdata_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL req_ready: got %b want 1", pdata_in_ready);
      end
      @(posedge clk); #1;
      pdata_in_valid = 1'b0;
      lat = 1;
      while (result_valid !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (pdata_in_ready !== 1'b0 || rd_en !== 1'b0 || result_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got rdy=%b rd_en=%b vld=%b want 0 0 0",
                  pdata_in_ready, rd_en, result_valid);
      end
      total++;
      if (result !== '0) begin
         bad++;
         $display("FAIL reset_result: got %0h want 0", result);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (pdata_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL idle_ready: got %b want 1", pdata_in_ready);
      end
   endtask

   task automatic test_empty_bucket();
      int unsigned lat;
      send_req(16'h0011, 8'h00, 1'b0, lat);
      total++;
      if (lat != 1) begin bad++; $display("FAIL empty_latency: got %0d want 1", lat); end
      total++;
      if (res.found !== 1'b0 || res.prev_ptr_val !== 1'b0 || res.chain_err !== 1'b0) begin
         bad++;
         $display("FAIL empty_flags: got found=%b pv=%b err=%b want 0 0 0",
                  res.found, res.prev_ptr_val, res.chain_err);
      end
      total++;
      if (nreads != 0) begin bad++; $display("FAIL empty_reads: got %0d want 0", nreads); end
      total++;
      if (res.pdata !== req_last) begin
         bad++;
         $display("FAIL empty_pdata: got %0h want %0h", res.pdata, req_last);
      end
      release_result();
      total++;
      if (result_valid !== 1'b0 || pdata_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL empty_release: got vld=%b rdy=%b want 0 1", result_valid, pdata_in_ready);
      end
   endtask

   task automatic test_hit_head();
      int unsigned lat;
      set_ram(5, 16'h0011, 16'hA5A5, 8'd9, 1'b1);
      send_req(16'h0011, 8'd5, 1'b1, lat);
      total++;
      if (lat != 2) begin bad++; $display("FAIL head_latency: got %0d want 2", lat); end
      total++;
      if (res.found !== 1'b1 || res.found_ptr !== 8'd5 || res.prev_ptr_val !== 1'b0) begin
         bad++;
         $display("FAIL head_hit: got found=%b fptr=%0d pv=%b want 1 5 0",
                  res.found, res.found_ptr, res.prev_ptr_val);
      end
      total++;
      if (res.value !== 16'hA5A5) begin
         bad++;
         $display("FAIL head_value: got %0h want a5a5", res.value);
      end
      release_result();
   endtask

   task automatic test_hit_third();
      int unsigned lat;
      set_ram(5, 16'h0011, 16'hA5A5, 8'd9, 1'b1);
      set_ram(9, 16'h0022, 16'h0909, 8'd2, 1'b1);
      set_ram(2, 16'h0033, 16'h0202, 8'd0, 1'b0);
      send_req(16'h0033, 8'd5, 1'b1, lat);
      total++;
      if (lat != 4) begin bad++; $display("FAIL third_latency: got %0d want 4", lat); end
      total++;
      if (res.found !== 1'b1 || res.found_ptr !== 8'd2 || res.prev_ptr !== 8'd9
          || res.prev_ptr_val !== 1'b1 || res.value !== 16'h0202) begin
         bad++;
         $display("FAIL third_hit: got found=%b fptr=%0d pp=%0d pv=%b val=%0h want 1 2 9 1 202",
                  res.found, res.found_ptr, res.prev_ptr, res.prev_ptr_val, res.value);
      end
      total++;
      if (nreads != 3 || rd_log[0] !== 8'd5 || rd_log[1] !== 8'd9 || rd_log[2] !== 8'd2) begin
         bad++;
         $display("FAIL third_reads: got n=%0d %0d,%0d,%0d want 3 5,9,2",
                  nreads, rd_log[0], rd_log[1], rd_log[2]);
      end
      release_result();
   endtask

   task automatic test_tail_miss();
      int unsigned lat;
      set_ram(5, 16'h0011, 16'hA5A5, 8'd9, 1'b1);
      set_ram(9, 16'h0022, 16'h0909, 8'd0, 1'b0);
      send_req(16'h0044, 8'd5, 1'b1, lat);
      total++;
      if (lat != 3) begin bad++; $display("FAIL tail_latency: got %0d want 3", lat); end
      total++;
      if (res.found !== 1'b0 || res.prev_ptr !== 8'd9 || res.prev_ptr_val !== 1'b1
          || res.chain_err !== 1'b0) begin
         bad++;
         $display("FAIL tail_miss: got found=%b pp=%0d pv=%b err=%b want 0 9 1 0",
                  res.found, res.prev_ptr, res.prev_ptr_val, res.chain_err);
      end
      release_result();
   endtask

   task automatic test_loop_backpressure();
      int unsigned lat;
      logic [$bits(ht_search_result_t)-1:0] snap;
      set_ram(3, 16'h0030, 16'h3333, 8'd4, 1'b1);
      set_ram(4, 16'h0040, 16'h4444, 8'd3, 1'b1);
      send_req(16'h0055, 8'd3, 1'b1, lat);
      total++;
      if (lat != 5) begin bad++; $display("FAIL loop_latency: got %0d want 5", lat); end
      total++;
      if (res.found !== 1'b0 || res.chain_err !== 1'b1) begin
         bad++;
         $display("FAIL loop_err: got found=%b err=%b want 0 1", res.found, res.chain_err);
      end
      total++;
      if (nreads != 4 || rd_log[0] !== 8'd3 || rd_log[1] !== 8'd4
          || rd_log[2] !== 8'd3 || rd_log[3] !== 8'd4) begin
         bad++;
         $display("FAIL loop_reads: got n=%0d want 4 at 3,4,3,4", nreads);
      end
      snap = result;
      pdata_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (result_valid !== 1'b1 || result !== snap || pdata_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_%0d: got vld=%b rdy=%b stable=%b want 1 0 1",
                     i, result_valid, pdata_in_ready, result === snap);
         end
      end
      pdata_in_valid = 1'b0;
      release_result();
      total++;
      if (result_valid !== 1'b0 || pdata_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL loop_release: got vld=%b rdy=%b want 0 1", result_valid, pdata_in_ready);
      end
   endtask

   task automatic test_reset_mid_walk();
      ht_pdata_t   r;
      int unsigned lat;
      set_ram(5, 16'h0011, 16'h5555, 8'd9, 1'b1);
      set_ram(9, 16'h0099, 16'h9999, 8'd0, 1'b0);
      r = '0;
      r.cmd.key      = 16'h0077;
      r.head_ptr     = 8'd5;
      r.head_ptr_val = 1'b1;
      pdata_in       = r;
      pdata_in_valid = 1'b1;
      @(posedge clk); #1;
      pdata_in_valid = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if (result_valid !== 1'b0 || pdata_in_ready !== 1'b0 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_walk_%0d: got vld=%b rdy=%b rd_en=%b want 0 0 0",
                     i, result_valid, pdata_in_ready, rd_en);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (result_valid !== 1'b0 || pdata_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_after: got vld=%b rdy=%b want 0 1", result_valid, pdata_in_ready);
      end
      send_req(16'h0011, 8'd5, 1'b1, lat);
      total++;
      if (lat != 2 || res.found !== 1'b1 || res.found_ptr !== 8'd5 || res.value !== 16'h5555
          || res.pdata.cmd.key !== 16'h0011) begin
         bad++;
         $display("FAIL rst_new_req: got lat=%0d found=%b fptr=%0d val=%0h key=%0h want 2 1 5 5555 11",
                  lat, res.found, res.found_ptr, res.value, res.pdata.cmd.key);
      end
      release_result();
   endtask

   initial begin
      clk            = 1'b0;
      rst            = 1'b1;
      pdata_in       = '0;
      pdata_in_valid = 1'b0;
      result_ready   = 1'b0;
      rd_data        = '0;
      nreads         = 0;
      total          = 0;
      bad            = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      for (int i = 0; i < 16; i++) rd_log[i] = '0;
      test_reset();
      test_empty_bucket();
      test_hit_head();
      test_hit_third();
      test_tail_miss();
      test_loop_backpressure();
      test_reset_mid_walk();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_table_search.md
Name: data_table_search

Overview:
- Pipeline stage directly downstream of the head-table stage.
- Takes each request carrying its bucket head pointer and walks the bucket's linked list in the data RAM, one entry per cycle, comparing stored keys against the request key.
- Emits one registered search result per request: hit/miss, matched pointer, predecessor pointer and value. The downstream insert/delete/search executor uses this result.
- Processes one request at a time, so request order is preserved.

Parameters:
- MAX_CHAIN, 8, maximum number of entries examined per request; reaching it without a hit or an end of chain raises chain_err.
- PTR_WIDTH, 8, data RAM address width; must equal the package constant for head pointers.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- pdata_in_i  in  $bits(ht_pdata_t)  request: cmd.opcode, cmd.key, bucket, head_ptr, head_ptr_val
- pdata_in_valid_i  in  1  request valid
- pdata_in_ready_o  out  1  request ready
- rd_addr_o  out  PTR_WIDTH  data RAM read address
- rd_en_o  out  1  data RAM read enable
- rd_data_i  in  $bits(data_ram_data_t)  data RAM read data: key, value, next_ptr, next_ptr_val; valid 1 cycle after rd_en_o
- result_o  out  $bits(ht_search_result_t)  fields: pdata, found, found_ptr, prev_ptr, prev_ptr_val, value, chain_err
- result_valid_o  out  1  result valid
- result_ready_i  in  1  result ready

Behaviour:
- State machine with three states: IDLE, CHECK, OUT. The reset state is IDLE.
- Reset values: result_valid_o=0, result_o='0, hop counter=0, cur_ptr=0, prev_ptr=0, prev_ptr_val=0.
- While rst_i=1, pdata_in_ready_o=0 and rd_en_o=0.
- pdata_in_ready_o = (state==IDLE). Accept = valid && ready. On accept, latch pdata_in_i.
- rd_addr_o/rd_en_o are combinational:
  - IDLE: rd_addr_o=pdata_in_i.head_ptr; rd_en_o = accept && head_ptr_val.
  - CHECK: rd_addr_o=rd_data_i.next_ptr; rd_en_o asserted on a continue-walk decision.
- IDLE transitions on accept:
  - head_ptr_val=0 → OUT with found=0, prev_ptr_val=0, chain_err=0.
  - head_ptr_val=1 → CHECK with cur_ptr=head_ptr, hop=1, prev_ptr_val=0.
- CHECK evaluates rd_data_i every cycle, in this priority order:
  1. rd_data_i.key==latched key → OUT with found=1, found_ptr=cur_ptr, value=rd_data_i.value; prev_ptr/prev_ptr_val kept as is (prev_ptr_val=0 means the hit is the head).
  2. next_ptr_val=0 → OUT with found=0, prev_ptr=cur_ptr, prev_ptr_val=1 (tail pointer, used for append).
  3. hop==MAX_CHAIN → OUT with found=0, chain_err=1.
  4. Otherwise continue the walk: issue read of next_ptr, prev_ptr<=cur_ptr, prev_ptr_val<=1, cur_ptr<=next_ptr, hop<=hop+1, stay in CHECK.
- Hop counter width is $clog2(MAX_CHAIN+1) and cannot exceed MAX_CHAIN, so it never wraps.
- OUT: result_o registered; result_valid_o=1 and held stable until result_ready_i=1. The cycle after the handshake: state IDLE, result_valid_o=0. No new accept occurs in the handshake cycle.
- Latency, accept in cycle 0:
  - Empty bucket: result_valid_o in cycle 1.
  - Hit or tail at chain position n (1-based): result_valid_o in cycle n+1.
  - Throughput: one request per (latency+1) cycles minimum.
- result_o.pdata is a copy of the latched request; head_ptr fields are passed through unchanged.
- Write hazards are excluded by the upstream same-bucket backpressure and this block's single-request occupancy. There is no internal RAM write port and no hazard check.
- An asynchronous reset mid-walk returns the block to IDLE immediately and drops the in-flight request; no result is emitted.
- result_ready_i high while not in OUT has no effect.

Decomposition:
- The hash_table package adds:
  - data_ram_data_t {key, value, next_ptr, next_ptr_val}
  - ht_search_result_t
  - Constants KEY_WIDTH, VALUE_WIDTH, and default MAX_CHAIN_LEN
- Single module with no sub-module. The data RAM instance and its write port live in the downstream executor/top level; this block owns only a read port.
- Simulation-only print of each result (opcode, key, found, found_ptr, chain_err), excluded from synthesis.

Test Plan:
1. Empty bucket: key=0x11, head_ptr_val=0 → cycle 1: found=0, prev_ptr_val=0, chain_err=0, and no rd_en_o pulse.
2. Hit at head: head_ptr=5, RAM[5].key=0x11 → cycle 2: found=1, found_ptr=5, prev_ptr_val=0, value=RAM[5].value.
3. Hit at 3rd entry: chain 5→9→2, key at 2 → cycle 4: found=1, found_ptr=2, prev_ptr=9, prev_ptr_val=1, with exactly 3 reads at addresses 5, 9, 2.
4. Miss on a 2-entry chain: 5→9, neither matches → cycle 3: found=0, prev_ptr=9, prev_ptr_val=1, chain_err=0.
5. Loop and backpressure: MAX_CHAIN=4, chain 3→4→3 with no match → chain_err=1 after 4 reads. Hold result_ready_i=0 for 5 cycles → result_o stable, pdata_in_ready_o=0 throughout. Release → IDLE the next cycle.
6. Reset mid-walk: assert rst_i during CHECK on chain 5→9 → result_valid_o=0 and pdata_in_ready_o=0 while reset is high. A new request after release completes normally with no stale result.
